multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Multi-cycle control FSM for the KGP-RISC core. Consumes the 6-bit opcode produced by instruction decode plus memory and flag handshakes, and sequences fetch, decode, execute, memory and writeback. It produces every datapath enable: PC, IR, register file, memory and mux selects. It sits between the instruction memory/IR, the decode stage and the ALU/register file.

## Interface

**Parameters**
- `FETCH_TIMEOUT`, default 16: cycles FETCH/MEM may wait on `mem_ready` before raising `mem_error`.

**Ports**
- `clk` — in, 1: rising-edge clock.
- `rst` — in, 1: synchronous, active-high reset.
- `opcode` — in, 6: opcode from decode; must be valid from DECODE onward.
- `mem_ready` — in, 1: memory completion strobe, sampled in FETCH/MEM.
- `branch_cond` — in, 1: condition-flag result for conditional branches.
- `pc_write` — out, 1: load PC.
- `pc_src` — out, 2: PC source: 00 = PC+4, 01 = PC+offset, 10 = label, 11 = rs.
- `ir_write` — out, 1: load instruction register.
- `mem_read` — out, 1: memory read request.
- `mem_write` — out, 1: memory write request.
- `alu_src_imm` — out, 1: ALU operand B selects immediate/shift.
- `reg_write` — out, 1: register-file write enable.
- `mem_to_reg` — out, 1: writeback data from memory.
- `instr_retired` — out, 1: one-cycle pulse per completed instruction.
- `halted` — out, 1: FSM in HALT.
- `mem_error` — out, 1: sticky timeout flag.
- `state` — out, 3: current state, for debug.
- `retired_count` — out, 32: retired-instruction count (see Configuration).

## Operation

- States and encodings: FETCH = 0, DECODE = 1, EXECUTE = 2, MEM = 3, WRITEBACK = 4, HALT = 5, ERROR = 6.
- Opcode class is `opcode[5:3]`:
  - 000: register ALU.
  - 001: immediate/shift ALU.
  - 010: load/store; `opcode[0]=1` means store.
  - 011: conditional branch.
  - 100: jump/call; `opcode[0]=1` means jump-register.
  - 111: halt.
  - 101 and 110: NOP.
- **FETCH:** `mem_read=1` until `mem_ready`. In the `mem_ready` cycle, assert `ir_write=1`, `pc_write=1` and `pc_src=00`, then go to DECODE.
- **DECODE:** no enables. Class-based transitions:
  - halt: go to HALT.
  - NOP: pulse `instr_retired`, go to FETCH.
  - otherwise: go to EXECUTE.
- **EXECUTE:**
  - ALU classes: `alu_src_imm=1` for class 001; go to WRITEBACK.
  - load/store: `alu_src_imm=1`; go to MEM.
  - branch: `pc_write=branch_cond`, `pc_src=01`, `instr_retired=1`; go to FETCH.
  - jump: `pc_write=1`, `pc_src=10` (or 11 if `opcode[0]`), `instr_retired=1`; go to FETCH.
- **MEM:** hold `mem_read` (load) or `mem_write` (store) until `mem_ready`.
  - load: go to WRITEBACK.
  - store: pulse `instr_retired`, go to FETCH.
- **WRITEBACK:** `reg_write=1`, `mem_to_reg=1` for load, `instr_retired=1`; go to FETCH.
- **HALT:** `halted=1`, all enables 0. Only `rst` exits.
- **Timeout:** a wait counter clears on entering FETCH or MEM. If it reaches `FETCH_TIMEOUT` without `mem_ready`, set `mem_error` and go to ERROR.
- **ERROR:** all enables 0, `halted=1`. Only `rst` exits.
- `mem_ready` outside FETCH/MEM is ignored.

## Timing

- Outputs are combinational from the state register, plus `mem_ready`/`branch_cond`/`opcode`. No output register stage.
- `rst` high at an edge:
  - state becomes FETCH; wait counter, `mem_error` and `retired_count` become 0.
  - while `rst` is high, all outputs are forced to 0.
  - `rst` mid-instruction aborts it with no retire pulse and no partial write.
- First `mem_read` is asserted in the first cycle after `rst` deasserts.
- Cycle counts with zero-wait memory (`mem_ready` high on first request cycle):
  - ALU: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - branch/jump: 3 cycles.
  - NOP: 2 cycles.
- Each wait cycle adds 1.
- Timeout boundary: `mem_ready` arriving in the same cycle the counter hits `FETCH_TIMEOUT` counts as success; no error.

## Configuration

- Macro: `SEQ_RETIRE_COUNTER_EN`.
- Defined: `retired_count` increments by 1 on every `instr_retired` and wraps from 0xFFFFFFFF to 0.
- Undefined: the port remains and is tied to 0; no counter flops are synthesized.

## Test plan

- **Reset:** `rst` high 2 cycles, then low with `mem_ready=1` → `mem_read=1` in cycle 1, `state`=0, all other outputs 0 during reset.
- **R-type and load:** R-type (`opcode=000010`) then load (`010000`), zero-wait → `reg_write` in cycles 4 and 9, `mem_to_reg=1` only in cycle 9, two `instr_retired` pulses.
- **Branch:** `011000` with `branch_cond=1` → `pc_write=1`, `pc_src=01` in cycle 3. With `branch_cond=0` → `pc_write=0`, still retires.
- **Memory wait:** store with `mem_ready` delayed 3 cycles in MEM → `mem_write` high 4 cycles, store latency 7, no `reg_write`.
- **Timeout:** `FETCH_TIMEOUT=16`, `mem_ready` never asserted → `mem_error`=1 and `state`=6 after 16 FETCH cycles. `mem_ready` arriving on cycle 16 → no error.
- **Halt and counter:** `111000` → `halted`=1, outputs idle for 20 cycles, `rst` recovers. With macro defined, 3 retired instructions → `retired_count`=3.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the KGP-RISC core: fetch, decode, execute, memory, writeback.
// Optional retired-instruction counter enabled by defining SEQ_RETIRE_COUNTER_EN.
module multicycle_sequencer #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  input  logic        branch_cond,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        instr_retired,
  output logic        halted,
  output logic        mem_error,
  output logic [2:0]  state,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam logic [2:0] CLS_ALU_R  = 3'b000;
  localparam logic [2:0] CLS_ALU_I  = 3'b001;
  localparam logic [2:0] CLS_LDST   = 3'b010;
  localparam logic [2:0] CLS_BRANCH = 3'b011;
  localparam logic [2:0] CLS_JUMP   = 3'b100;
  localparam logic [2:0] CLS_NOP_A  = 3'b101;
  localparam logic [2:0] CLS_NOP_B  = 3'b110;
  localparam logic [2:0] CLS_HALT   = 3'b111;

  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_error_q;
  logic             waiting;
  logic             timeout_hit;

  logic [2:0] op_cls;
  logic       op_sub;
  logic       unused_opcode_bits;

  logic       pc_write_c;
  logic [1:0] pc_src_c;
  logic       ir_write_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       alu_src_imm_c;
  logic       reg_write_c;
  logic       mem_to_reg_c;
  logic       retire_c;
  logic       halted_c;

  assign op_cls             = opcode[5:3];
  assign op_sub             = opcode[0];
  assign unused_opcode_bits = ^opcode[2:1];

  // Counter runs only while a memory handshake is outstanding.
  assign waiting = ((cur_state == S_FETCH) || (cur_state == S_MEM)) && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= S_FETCH;
      wait_cnt    <= '0;
      mem_error_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= waiting ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) begin
        mem_error_q <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    timeout_hit   = 1'b0;
    pc_write_c    = 1'b0;
    pc_src_c      = 2'b00;
    ir_write_c    = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    alu_src_imm_c = 1'b0;
    reg_write_c   = 1'b0;
    mem_to_reg_c  = 1'b0;
    retire_c      = 1'b0;
    halted_c      = 1'b0;

    case (cur_state)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          pc_src_c   = 2'b00;
          nxt_state  = S_DECODE;
        end else if (wait_cnt == TMO_LAST) begin
          timeout_hit = 1'b1;
          nxt_state   = S_ERROR;
        end
      end

      S_DECODE: begin
        case (op_cls)
          CLS_HALT:             nxt_state = S_HALT;
          CLS_NOP_A, CLS_NOP_B: begin
            retire_c  = 1'b1;
            nxt_state = S_FETCH;
          end
          default:              nxt_state = S_EXECUTE;
        endcase
      end

      S_EXECUTE: begin
        case (op_cls)
          CLS_ALU_R: nxt_state = S_WRITEBACK;
          CLS_ALU_I: begin
            alu_src_imm_c = 1'b1;
            nxt_state     = S_WRITEBACK;
          end
          CLS_LDST: begin
            alu_src_imm_c = 1'b1;
            nxt_state     = S_MEM;
          end
          CLS_BRANCH: begin
            pc_write_c = branch_cond;
            pc_src_c   = 2'b01;
            retire_c   = 1'b1;
            nxt_state  = S_FETCH;
          end
          CLS_JUMP: begin
            pc_write_c = 1'b1;
            pc_src_c   = op_sub ? 2'b11 : 2'b10;
            retire_c   = 1'b1;
            nxt_state  = S_FETCH;
          end
          // Only reachable if opcode changed after DECODE; drop the instruction.
          default:   nxt_state = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_write_c = op_sub;
        mem_read_c  = !op_sub;
        if (mem_ready) begin
          if (op_sub) begin
            retire_c  = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WRITEBACK;
          end
        end else if (wait_cnt == TMO_LAST) begin
          timeout_hit = 1'b1;
          nxt_state   = S_ERROR;
        end
      end

      S_WRITEBACK: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (op_cls == CLS_LDST) && !op_sub;
        retire_c     = 1'b1;
        nxt_state    = S_FETCH;
      end

      S_HALT:  halted_c = 1'b1;
      S_ERROR: halted_c = 1'b1;

      default: nxt_state = S_FETCH;
    endcase
  end

  // Reset forces every output low, including mid-instruction enables.
  assign pc_write      = pc_write_c    & ~rst;
  assign pc_src        = pc_src_c      & {2{~rst}};
  assign ir_write      = ir_write_c    & ~rst;
  assign mem_read      = mem_read_c    & ~rst;
  assign mem_write     = mem_write_c   & ~rst;
  assign alu_src_imm   = alu_src_imm_c & ~rst;
  assign reg_write     = reg_write_c   & ~rst;
  assign mem_to_reg    = mem_to_reg_c  & ~rst;
  assign instr_retired = retire_c      & ~rst;
  assign halted        = halted_c      & ~rst;
  assign mem_error     = mem_error_q   & ~rst;
  assign state         = rst ? 3'd0 : cur_state;

`ifdef SEQ_RETIRE_COUNTER_EN
  logic [31:0] retire_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire_c) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign retired_count = rst ? 32'd0 : retire_cnt;
`else
  assign retired_count = 32'd0;
`endif

endmodule
